axi4lite_slave_regfile: RTL

- AXI4-Lite responder (slave) holding a small register file; the target end of the AXI4-Lite master transactions driven from the tt_um_axi4lite_top pins.
- Accepts write address/data on AW/W, returns a response on B; accepts read address on AR, returns data and response on R.
- Register contents are also exposed as a flat vector for debug/pin muxing.

---
 rtl/axi4lite_slave_regfile_if.sv | 33 +++
 rtl/axi4lite_slave_regfile.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/axi4lite_slave_regfile_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) shared by the register-file
// responder and whatever drives it; master and slave modports give the directions.
interface axi4lite_slave_regfile_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite responder with a small word-indexed register file and independent read/write FSMs.
// Define AXI4LITE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4lite_slave_regfile #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  axi4lite_slave_regfile_if.slave        bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat_o
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4LITE_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif
  localparam logic [ADDR_WIDTH:0] NREGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  wstate_e                               wstate_q;
  rstate_e                               rstate_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs_q;
  logic                                  aw_cap_q, w_cap_q;
  logic [ADDR_WIDTH-1:0]                 awaddr_q;
  logic [DATA_WIDTH-1:0]                 wdata_q;
  logic                                  awready_q, wready_q, bvalid_q;
  logic [1:0]                            bresp_q;
  logic                                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0]                 rdata_q;
  logic [1:0]                            rresp_q;

  logic                                  aw_hs_d, w_hs_d, aw_cap_d, w_cap_d;
  logic                                  wr_fire_d, wr_legal_d, rd_legal_d;
  logic [ADDR_WIDTH-1:0]                 wr_addr_d;
  logic [DATA_WIDTH-1:0]                 wr_data_d, rd_data_d;

  // Handshake detection and write/read operand selection (bypass the holding regs on the fire edge).
  always_comb begin
    aw_hs_d    = bus.awvalid && awready_q;
    w_hs_d     = bus.wvalid && wready_q;
    aw_cap_d   = aw_cap_q || aw_hs_d;
    w_cap_d    = w_cap_q || w_hs_d;
    wr_addr_d  = aw_hs_d ? bus.awaddr : awaddr_q;
    wr_data_d  = w_hs_d ? bus.wdata : wdata_q;
    wr_fire_d  = (wstate_q == W_IDLE) && aw_cap_d && w_cap_d;
    wr_legal_d = ({1'b0, wr_addr_d} < NREGS_W);
    rd_legal_d = ({1'b0, bus.araddr} < NREGS_W);
    rd_data_d  = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.araddr == ADDR_WIDTH'(i)) begin
        rd_data_d = regs_q[i];
      end else begin
        rd_data_d = rd_data_d;
      end
    end
  end

  // Write FSM: capture AW and W in any order, commit the register and raise B on the second one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      regs_q    <= '0;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      awaddr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs_d) awaddr_q <= bus.awaddr;
          if (w_hs_d)  wdata_q  <= bus.wdata;
          if (wr_fire_d) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wr_addr_d == ADDR_WIDTH'(i)) regs_q[i] <= wr_data_d;
            end
            aw_cap_q  <= 1'b1;
            w_cap_q   <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_legal_d ? RESP_OKAY : RESP_OOR;
            wstate_q  <= W_RESP;
          end else begin
            aw_cap_q  <= aw_cap_d;
            w_cap_q   <= w_cap_d;
            awready_q <= !aw_cap_d;
            wready_q  <= !w_cap_d;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: begin
          wstate_q  <= W_IDLE;
          bvalid_q  <= 1'b0;
          aw_cap_q  <= 1'b0;
          w_cap_q   <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Read FSM: sample the pre-edge register value on AR and hold R until the master takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (bus.arvalid) begin
            rdata_q   <= rd_data_d;
            rresp_q   <= rd_legal_d ? RESP_OKAY : RESP_OOR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: begin
          rstate_q  <= R_IDLE;
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign regs_flat_o = regs_q;

endmodule
